// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions used by the vectoring block and the rotator.
// Binary angles are kept in a 64-bit full-scale form and right-shifted to the phase width in use.
package cordic_pkg;

    // Full-scale binary angles: PI is the MSB of a 64-bit word.
    localparam logic [63:0] PI   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] PI_2 = 64'h4000_0000_0000_0000;

    // CORDIC gain K ~= 1.646760 in Q1.15.
    localparam logic [15:0] CORDIC_K_Q = 16'd53961;

    // acc_t is logic signed [acc_w(WIDTH)-1:0]; arg_t is logic signed [arg_w(WIDTH)-1:0].
    function automatic int acc_w(input int width);
        return width + 2;
    endfunction

    function automatic int arg_w(input int width);
        return 2 * width;
    endfunction

    // round(atan(2^-n) * 2^(width-1) / pi), evaluated at elaboration.
    function automatic longint atan_table(input int n, input int width);
        real x;
        x = $atan(1.0 / (2.0 ** n)) * (2.0 ** (width - 1)) / 3.14159265358979323846;
        return longint'($floor(x + 0.5));
    endfunction

endpackage

// File: rtl/vectorize_stage.sv
// One registered vectoring micro-rotation: drives im toward zero and accumulates the angle.
// The valid/last/zero sideband is carried with the sample under the same enable.
module vectorize_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 0,
    parameter logic signed [arg_w(WIDTH)-1:0] PHI = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             en,
    input  logic                             vld,
    input  logic                             last,
    input  logic                             zero,
    input  logic signed [acc_w(WIDTH)-1:0]   re,
    input  logic signed [acc_w(WIDTH)-1:0]   im,
    input  logic signed [arg_w(WIDTH)-1:0]   ph,
    output logic                             vld_q,
    output logic                             last_q,
    output logic                             zero_q,
    output logic signed [acc_w(WIDTH)-1:0]   re_q,
    output logic signed [acc_w(WIDTH)-1:0]   im_q,
    output logic signed [arg_w(WIDTH)-1:0]   ph_q
);
    localparam int AW = acc_w(WIDTH);

    typedef logic signed [AW-1:0] acc_t;

    acc_t re_sh;
    acc_t im_sh;

    assign re_sh = re >>> SHIFT;
    assign im_sh = im >>> SHIFT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            zero_q <= 1'b0;
            re_q   <= '0;
            im_q   <= '0;
            ph_q   <= '0;
        end else if (en) begin
            vld_q  <= vld;
            last_q <= last;
            zero_q <= zero;
            if (!im[AW-1]) begin
                re_q <= re + im_sh;
                im_q <= im - re_sh;
                ph_q <= ph + PHI;
            end else begin
                re_q <= re - im_sh;
                im_q <= im + re_sh;
                ph_q <= ph - PHI;
            end
        end
    end

endmodule

// File: rtl/vectorize.sv
// CORDIC vectoring block: streamed (I, Q) in, magnitude and binary-angle phase out.
// One sample per clock; any output stall freezes the entire pipe.
module vectorize
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [2*WIDTH-1:0]   s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [3*WIDTH-1:0]   m_data,
    output logic                 m_last
);
    localparam int AW = acc_w(WIDTH);
    localparam int GW = arg_w(WIDTH);

    typedef logic signed [AW-1:0] acc_t;
    typedef logic signed [GW-1:0] arg_t;

    // +PI/2 and -PI/2 (== 3*PI/2 modulo a full turn) at the phase width.
    localparam arg_t PH_POS = arg_t'(PI_2 >> (64 - GW));
    localparam arg_t PH_NEG = arg_t'((PI | PI_2) >> (64 - GW));

    logic                    advance;
    logic signed [WIDTH-1:0] in_i;
    logic signed [WIDTH-1:0] in_q;
    logic                    in_zero;

    acc_t pre_re;
    acc_t pre_im;
    arg_t pre_ph;

    logic s0_vld;
    logic s0_last;
    logic s0_zero;
    acc_t s0_re;
    acc_t s0_im;
    arg_t s0_ph;

    logic [STAGES:0]          vld_pipe;
    logic [STAGES:0]          last_pipe;
    logic [STAGES:0]          zero_pipe;
    logic [STAGES:0][AW-1:0]  re_pipe;
    logic [STAGES:0][AW-1:0]  im_pipe;
    logic [STAGES:0][GW-1:0]  ph_pipe;

    logic [WIDTH-1:0] mag;
    logic             unused_bits;

    assign advance = !m_valid || m_ready;
    assign s_ready = advance;

    assign in_i    = s_data[WIDTH-1:0];
    assign in_q    = s_data[2*WIDTH-1 -: WIDTH];
    assign in_zero = (in_i == '0) && (in_q == '0);

    // Fold the left half-plane onto the right so the micro-rotations converge.
    always_comb begin
        pre_re = acc_t'(in_i);
        pre_im = acc_t'(in_q);
        pre_ph = '0;
        if (in_i[WIDTH-1]) begin
            if (!in_q[WIDTH-1]) begin
                pre_re = acc_t'(in_q);
                pre_im = -acc_t'(in_i);
                pre_ph = PH_POS;
            end else begin
                pre_re = -acc_t'(in_q);
                pre_im = acc_t'(in_i);
                pre_ph = PH_NEG;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_vld  <= 1'b0;
            s0_last <= 1'b0;
            s0_zero <= 1'b0;
            s0_re   <= '0;
            s0_im   <= '0;
            s0_ph   <= '0;
        end else if (advance) begin
            s0_vld  <= s_valid;
            s0_last <= s_last;
            s0_zero <= in_zero;
            s0_re   <= pre_re;
            s0_im   <= pre_im;
            s0_ph   <= pre_ph;
        end
    end

    assign vld_pipe[0]  = s0_vld;
    assign last_pipe[0] = s0_last;
    assign zero_pipe[0] = s0_zero;
    assign re_pipe[0]   = s0_re;
    assign im_pipe[0]   = s0_im;
    assign ph_pipe[0]   = s0_ph;

    for (genvar n = 0; n < STAGES; n++) begin : g_stage
        vectorize_stage #(
            .WIDTH (WIDTH),
            .SHIFT (n),
            .PHI   (arg_t'(atan_table(n, GW)))
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (advance),
            .vld     (vld_pipe[n]),
            .last    (last_pipe[n]),
            .zero    (zero_pipe[n]),
            .re      (re_pipe[n]),
            .im      (im_pipe[n]),
            .ph      (ph_pipe[n]),
            .vld_q   (vld_pipe[n+1]),
            .last_q  (last_pipe[n+1]),
            .zero_q  (zero_pipe[n+1]),
            .re_q    (re_pipe[n+1]),
            .im_q    (im_pipe[n+1]),
            .ph_q    (ph_pipe[n+1])
        );
    end

    // re_final is K*|z| <= 2^17 and never negative, so bits [WIDTH:1] hold |z|*K/2.
    assign mag     = re_pipe[STAGES][WIDTH:1];
    assign m_valid = vld_pipe[STAGES];
    assign m_last  = last_pipe[STAGES];
    assign m_data  = zero_pipe[STAGES] ? '0 : {ph_pipe[STAGES], mag};

    assign unused_bits = ^{im_pipe[STAGES], re_pipe[STAGES][AW-1], re_pipe[STAGES][0]};

endmodule

// File: tb/tb_vectorize.sv
// Scoreboard bench for vectorize: a real-valued model predicts each accepted sample,
// results are popped in order as the DUT hands them off.
module tb_vectorize;
    localparam int  W       = 16;
    localparam int  ST      = 16;
    localparam int  MAG_TOL = 4;
    localparam int  PH_TOL  = 1 << 17;
    localparam real PI_R    = 3.14159265358979323846;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [2*W-1:0] s_data  = '0;
    logic           s_last  = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic [3*W-1:0] m_data;
    logic           m_last;

    vectorize #(.WIDTH(W), .STAGES(ST)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        int     mag;
        longint ph;
        bit     zero;
        bit     last;
        bit     use_ph;
    } exp_t;

    exp_t           sbq[$];
    int             n_cmp  = 0;
    int             n_bad  = 0;
    int             n_in   = 0;
    bit             rnd_on = 1'b0;
    bit             held_v = 1'b0;
    logic [3*W-1:0] held_data = '0;
    logic           held_last = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
        longint d;
        d = obs - exp;
        n_cmp++;
        if (d > tol || d < -tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic exp_t model(input int i, input int q, input bit last, input int idx);
        exp_t e;
        real  r;
        real  a;
        r = $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
        a = $atan2(real'(q), real'(i));
        e.idx    = idx;
        e.last   = last;
        e.zero   = (i == 0) && (q == 0);
        e.mag    = int'($floor(0.82338 * r + 0.5));
        e.ph     = longint'($floor(a / PI_R * (2.0 ** 31) + 0.5));
        e.use_ph = (r >= 16384.0);
        return e;
    endfunction

    task automatic check_out(input exp_t e);
        logic [W-1:0]   mag;
        logic [2*W-1:0] ph;
        logic [2*W-1:0] eph;
        logic [2*W-1:0] dph;
        mag = m_data[W-1:0];
        ph  = m_data[3*W-1:W];
        eph = e.ph[2*W-1:0];
        dph = ph - eph;
        chk($sformatf("last#%0d", e.idx), m_last, e.last, 0);
        if (e.zero) begin
            chk($sformatf("zero_mag#%0d", e.idx), mag, 0, 0);
            chk($sformatf("zero_ph#%0d", e.idx), ph, 0, 0);
        end else begin
            chk($sformatf("mag#%0d", e.idx), mag, e.mag, MAG_TOL);
            if (e.use_ph)
                chk($sformatf("ph_err#%0d", e.idx), $signed(dph), 0, PH_TOL);
        end
    endtask

    // Input/output handshakes and stall stability are all observed on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            sbq.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_vld", m_valid, 1, 0);
                chk("hold_data", m_data, held_data, 0);
                chk("hold_last", m_last, held_last, 0);
            end
            held_v    = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            if (s_valid && s_ready) begin
                sbq.push_back(model($signed(s_data[W-1:0]), $signed(s_data[2*W-1:W]), s_last, n_in));
                n_in++;
            end
            if (m_valid && m_ready) begin
                if (sbq.size() == 0) chk("spurious_out", 1, 0, 0);
                else check_out(sbq.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd_on ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    // Called just after a rising edge; returns just after the edge that took the sample.
    task automatic send(input int i, input int q, input bit last);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data  = {16'(q), 16'(i)};
        s_last  = last;
        @(negedge clk);
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("send_timeout", w, 0, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic lat_probe(input int i, input int q);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = {16'(q), 16'(i)};
        s_last  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 40);
        chk("latency", n, ST + 1, 0);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sbq.size(), 0, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int quiet;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0, 0);
        chk("rst_m_last", m_last, 0, 0);
        chk("rst_m_data", m_data, 0, 0);
        chk("rst_s_ready", s_ready, 1, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        lat_probe(16384, 0);
        wait_drain();
        send(0, 16384, 1'b0);
        send(-16384, -16384, 1'b1);
        send(-16384, 0, 1'b0);
        send(-32768, -1, 1'b0);
        send(0, 0, 1'b1);
        send(32767, 32767, 1'b0);
        send(-32768, -32768, 1'b0);
        wait_drain();

        rnd_on = 1'b1;
        for (int k = 0; k < 200; k++) begin
            int gap;
            gap = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                 (k % 50) == 49);
        end
        rnd_on = 1'b0;
        wait_drain();

        for (int k = 0; k < 10; k++)
            send(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0, 0);
        chk("midrst_s_ready", s_ready, 1, 0);
        chk("midrst_m_data", m_data, 0, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid) quiet++;
        end
        chk("post_rst_quiet", quiet, 0, 0);
        @(posedge clk);
        #1;
        lat_probe(12000, -9000);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
